// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
// A request is accepted on any cycle with imem_req & imem_gnt; memory answers each accepted request
// with exactly one imem_rvalid beat, in request order, no earlier than the cycle after the grant.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests under a credit limit,
// buffers returned instructions with their PCs and drops in-flight fetches on redirect.
module if_fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                INST_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic                   sys_clk,
    input  logic                   rstn,
    if_fetch_unit_if.master        imem,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    input  logic                   id_ready,
    output logic                   inst_valid_if,
    output logic [ADDR_W-1:0]      pc_addr_if,
    output logic [INST_W-1:0]      fetched_inst_if
);
    localparam int                PTR_W      = $clog2(BUF_DEPTH);
    localparam int                CNT_W      = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pcq_mem   [BUF_DEPTH];
    logic [PTR_W-1:0]  pcq_wr, pcq_rd;
    logic [ADDR_W-1:0] fifo_pc   [BUF_DEPTH];
    logic [INST_W-1:0] fifo_inst [BUF_DEPTH];
    logic [PTR_W-1:0]  fifo_wr, fifo_rd;
    logic [CNT_W-1:0]  fifo_count, outstanding, discard;
    logic [CNT_W-1:0]  fifo_count_nxt, outstanding_nxt, discard_nxt;
    logic [CNT_W:0]    used;
    logic              grant, resp, drop, push, pop;

    assign used          = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem.imem_req  = rstn & ~redirect_valid & (used < DEPTH_C);
    assign imem.imem_addr = fetch_pc;

    assign grant = imem.imem_req & imem.imem_gnt;
    assign resp  = imem.imem_rvalid;
    assign drop  = resp & (discard != '0);
    assign push  = resp & ~drop & ~redirect_valid;
    assign pop   = inst_valid_if & id_ready & ~redirect_valid;

    assign inst_valid_if   = (fifo_count != '0);
    assign pc_addr_if      = inst_valid_if ? fifo_pc[fifo_rd] : '0;
    assign fetched_inst_if = inst_valid_if ? fifo_inst[fifo_rd] : '0;

    always_comb begin
        outstanding_nxt = outstanding;
        fifo_count_nxt  = fifo_count;
        discard_nxt     = discard;
        case ({grant, resp})
            2'b10:   outstanding_nxt = outstanding + 1'b1;
            2'b01:   outstanding_nxt = outstanding - 1'b1;
            default: outstanding_nxt = outstanding;
        endcase
        case ({push, pop})
            2'b10:   fifo_count_nxt = fifo_count + 1'b1;
            2'b01:   fifo_count_nxt = fifo_count - 1'b1;
            default: fifo_count_nxt = fifo_count;
        endcase
        // discard is a subset of outstanding: on redirect every fetch still in flight
        // after this cycle's response (already-doomed or live) becomes doomed.
        if (redirect_valid) begin
            fifo_count_nxt = '0;
            discard_nxt    = outstanding_nxt;
        end else if (drop) begin
            discard_nxt = discard - 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            fetch_pc    <= RESET_PC;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            fifo_count  <= fifo_count_nxt;
            discard     <= discard_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ALIGN_MASK;
            end else if (grant) begin
                fetch_pc <= fetch_pc + STEP;
            end
            if (grant) pcq_wr <= pcq_wr + 1'b1;
            if (resp)  pcq_rd <= pcq_rd + 1'b1;
            if (redirect_valid) begin
                fifo_wr <= '0;
                fifo_rd <= '0;
            end else begin
                if (push) fifo_wr <= fifo_wr + 1'b1;
                if (pop)  fifo_rd <= fifo_rd + 1'b1;
            end
        end
    end

    // Payload storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge sys_clk) begin
        if (grant) pcq_mem[pcq_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[fifo_wr]   <= pcq_mem[pcq_rd];
            fifo_inst[fifo_wr] <= imem.imem_rdata;
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge sys_clk) disable iff (!rstn)
        !(imem.imem_rvalid && outstanding == '0));
    a_discard_bounded: assert property (@(posedge sys_clk) disable iff (!rstn)
        discard <= outstanding);
endmodule
